// File: rtl/cpu_pkg.sv
// Shared definitions for the mini_CPU branch path: sequencer states,
// 2-bit predictor counter encoding and the branch instruction type.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } seq_state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] INSTR_BRANCH = 2'b10;

    // Saturating step of a 2-bit predictor counter toward the observed outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != ST) begin
            nxt = ctr + 2'd1;
        end else if (!taken && ctr != SNT) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating counters: one combinational read port and one
// synchronous update port. A same-cycle read of the updated entry sees the old value.
module bht_2bit
    import cpu_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctr_q [DEPTH];
    logic [1:0] ctr_d [DEPTH];

    assign rd_ctr = ctr_q[rd_idx];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_en) begin
            ctr_d[upd_idx] = ctr_next(ctr_q[upd_idx], upd_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Branch predictor front end plus misprediction recovery: redirects fetch and
// flushes the two wrong-path pipeline slots after an EX-stage mispredict.
module branch_sequencer
    import cpu_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_target,
    input  logic            BranchTaken,
    input  logic            stall,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispred_cnt
);

    // Handshake: there is no backpressure; resolve is a one-cycle strobe that is
    // accepted only in RUN and only when stall is low, otherwise it is dropped.

    seq_state_e      state_q, state_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
    logic [15:0]     branch_cnt_q, branch_cnt_d;
    logic [15:0]     mispred_cnt_q, mispred_cnt_d;

    logic            resolve;
    logic            mispredict;
    logic [PC_W-1:0] correct_pc;
    logic [1:0]      rd_ctr;
    logic            unused_bits;

    bht_2bit #(.IDX_W(IDX_W)) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (if_pc[IDX_W+1:2]),
        .rd_ctr    (rd_ctr),
        .upd_en    (resolve),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (BranchTaken)
    );

    assign pred_taken = rd_ctr[1];

    assign resolve    = ex_is_branch & ~stall & (state_q == RUN);
    assign mispredict = resolve & (BranchTaken != ex_pred_taken);
    assign correct_pc = BranchTaken ? ex_target : ex_pc + {{(PC_W-3){1'b0}}, 3'd4};

    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (mispredict) begin
                        state_d       = REDIRECT;
                        redirect_pc_d = correct_pc;
                    end
                end
                REDIRECT: state_d = DRAIN;
                DRAIN:    state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
        if (resolve && branch_cnt_q != 16'hFFFF) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
        if (mispredict && mispred_cnt_q != 16'hFFFF) begin
            mispred_cnt_d = mispred_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Decoded straight from state so an async reset clears them immediately.
    assign redirect    = (state_q == REDIRECT);
    assign flush       = (state_q != RUN);
    assign redirect_pc = redirect_pc_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    assign unused_bits = ^{rd_ctr[0], if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                           ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: prediction table, recovery sequencing,
// stall freeze and mid-recovery reset, with hand-computed expectations.
module tb_branch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        BranchTaken;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    branch_sequencer #(.IDX_W(4), .PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .ex_is_branch  (ex_is_branch),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .BranchTaken   (BranchTaken),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_branch(input logic [31:0] pc, input logic pt, input logic tk,
                              input logic [31:0] tgt);
        ex_is_branch  = 1'b1;
        ex_pc         = pc;
        ex_pred_taken = pt;
        BranchTaken   = tk;
        ex_target     = tgt;
    endtask

    task automatic check_seq(input string tag, input logic r, input logic f,
                             input logic [31:0] rpc, input logic [15:0] bc,
                             input logic [15:0] mc);
        check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
        check({tag, "_flush"}, {31'd0, flush}, {31'd0, f});
        check({tag, "_rpc"}, redirect_pc, rpc);
        check({tag, "_bcnt"}, {16'd0, branch_cnt}, {16'd0, bc});
        check({tag, "_mcnt"}, {16'd0, mispred_cnt}, {16'd0, mc});
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        check(tag, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    initial begin
        rst_n         = 1'b0;
        if_pc         = '0;
        ex_is_branch  = 1'b0;
        ex_pc         = '0;
        ex_pred_taken = 1'b0;
        ex_target     = '0;
        BranchTaken   = 1'b0;
        stall         = 1'b0;
        #1;

        // Reset state and table sweep
        check_seq("reset", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        for (int a = 0; a <= 32'h3C; a += 4) begin
            check_pred($sformatf("reset_pred_%0h", a), a, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_seq("post_reset", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);

        // Taken branch at 0x40, correctly predicted, three times: 01->10->11->11
        check_pred("p40_init", 32'h40, 1'b0);
        set_branch(32'h40, 1'b1, 1'b1, 32'h80);
        #1;
        check("p40_same_cycle_old", {31'd0, pred_taken}, 32'd0);
        tick();
        check_pred("p40_after1", 32'h40, 1'b1);
        check_seq("p40_u1", 1'b0, 1'b0, 32'h0, 16'd1, 16'd0);
        tick();
        check_pred("p40_after2", 32'h40, 1'b1);
        tick();
        check_pred("p40_after3", 32'h40, 1'b1);
        check_seq("p40_u3", 1'b0, 1'b0, 32'h0, 16'd3, 16'd0);
        // Two correctly predicted not-taken updates prove the counter held at 11
        set_branch(32'h40, 1'b0, 1'b0, 32'h80);
        tick();
        check_pred("p40_nt1", 32'h40, 1'b1);
        tick();
        ex_is_branch = 1'b0;
        check_pred("p40_nt2", 32'h40, 1'b0);
        check_pred("p44_untouched", 32'h44, 1'b0);
        check_seq("p40_done", 1'b0, 1'b0, 32'h0, 16'd5, 16'd0);

        // Taken mispredict at 0x100 (index 0, counter 01->10)
        set_branch(32'h100, 1'b0, 1'b1, 32'h200);
        tick();
        check_seq("mp_t1", 1'b1, 1'b1, 32'h200, 16'd6, 16'd1);
        check_pred("mp_t1_pred", 32'h100, 1'b1);
        // A mispredicting branch presented during REDIRECT and DRAIN is ignored
        set_branch(32'h100, 1'b1, 1'b0, 32'h300);
        tick();
        check_seq("mp_t2", 1'b0, 1'b1, 32'h200, 16'd6, 16'd1);
        check_pred("mp_t2_pred", 32'h100, 1'b1);
        tick();
        check_seq("mp_t3", 1'b0, 1'b0, 32'h200, 16'd6, 16'd1);
        check_pred("mp_t3_pred", 32'h100, 1'b1);
        // Resolution is accepted again in t+3
        set_branch(32'h44, 1'b1, 1'b1, 32'h400);
        tick();
        ex_is_branch = 1'b0;
        check_seq("mp_t4", 1'b0, 1'b0, 32'h200, 16'd7, 16'd1);
        check_pred("p44_after", 32'h44, 1'b1);

        // Not-taken mispredict at the top of the address space wraps to 0
        set_branch(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1234);
        tick();
        ex_is_branch = 1'b0;
        check_seq("wrap_t1", 1'b1, 1'b1, 32'h0, 16'd8, 16'd2);
        // Stall holds REDIRECT for three cycles
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_seq($sformatf("stall_redir_%0d", s), 1'b1, 1'b1, 32'h0, 16'd8, 16'd2);
        end
        stall = 1'b0;
        tick();
        check_seq("stall_drain", 1'b0, 1'b1, 32'h0, 16'd8, 16'd2);
        tick();
        check_seq("stall_run", 1'b0, 1'b0, 32'h0, 16'd8, 16'd2);

        // A branch presented under stall in RUN is not resolved
        stall = 1'b1;
        set_branch(32'h48, 1'b0, 1'b1, 32'h500);
        tick();
        check_seq("stall_run_br", 1'b0, 1'b0, 32'h0, 16'd8, 16'd2);
        check_pred("p48_frozen", 32'h48, 1'b0);
        stall = 1'b0;
        ex_is_branch = 1'b0;

        // Taken mispredict at 0x100 (counter 10->11), then reset in DRAIN
        set_branch(32'h100, 1'b0, 1'b1, 32'h208);
        tick();
        ex_is_branch = 1'b0;
        check_seq("rst_t1", 1'b1, 1'b1, 32'h208, 16'd9, 16'd3);
        tick();
        check_seq("rst_drain", 1'b0, 1'b1, 32'h208, 16'd9, 16'd3);
        rst_n = 1'b0;
        #1;
        check_seq("rst_async", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);
        check_pred("rst_p100", 32'h100, 1'b0);
        check_pred("rst_p44", 32'h44, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check_seq("rst_idle", 1'b0, 1'b0, 32'h0, 16'd0, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Branch prediction and misprediction-recovery controller for the mini_CPU pipeline. It supplies a taken/not-taken prediction to fetch from a table of 2-bit saturating counters. It consumes the EX-stage branch resolution from `brancher` (BranchTaken). On a misprediction it sequences the PC redirect and the two-cycle flush of the wrong-path instructions.

## Interface
Parameters:
- `IDX_W`, 4: predictor index width; table has 2^IDX_W entries.
- `PC_W`, 32: program counter width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_pc`  in  PC_W  PC currently being fetched.
- `pred_taken`  out  1  prediction for `if_pc`; MSB of the indexed counter; combinational.
- `ex_is_branch`  in  1  conditional branch (InstrType 2'b10) valid in EX this cycle.
- `ex_pc`  in  PC_W  PC of the EX branch.
- `ex_pred_taken`  in  1  prediction that was made for that branch, piped down from fetch.
- `ex_target`  in  PC_W  branch target computed in EX.
- `BranchTaken`  in  1  actual outcome from `brancher`.
- `stall`  in  1  pipeline stall; freezes this block.
- `redirect`  out  1  fetch must load `redirect_pc` this cycle.
- `redirect_pc`  out  PC_W  corrected fetch PC.
- `flush`  out  1  invalidate IF/ID and ID/EX this cycle.
- `branch_cnt`  out  16  resolved branches; saturating.
- `mispred_cnt`  out  16  mispredictions; saturating.

## Operation
- Index is `pc[IDX_W+1:2]` for both read (`if_pc`) and update (`ex_pc`).
- Counter encoding:
  - 00 strong-NT
  - 01 weak-NT
  - 10 weak-T
  - 11 strong-T
- Counter update: increment if taken, decrement if not taken. Saturates at 11 and 00.
- `resolve = ex_is_branch & ~stall & (state == RUN)`.
- `mispredict = resolve & (BranchTaken != ex_pred_taken)`.
- Correct PC is `ex_target` if BranchTaken, else `ex_pc + 4`. Addition is modulo 2^PC_W, so 0xFFFFFFFC + 4 = 0.
- FSM states RUN, REDIRECT, DRAIN:
  - RUN: on `mispredict`, go to REDIRECT and latch the correct PC into `redirect_pc`. Otherwise stay in RUN.
  - REDIRECT: `redirect`=1, `flush`=1. Go to DRAIN.
  - DRAIN: `flush`=1, `redirect`=0; this kills the instruction fetched during REDIRECT. Go to RUN.
- `ex_is_branch` is ignored in REDIRECT and DRAIN, because those instructions are being flushed. In those states there are no table updates and no counter increments.
- On `resolve`:
  - update the table entry;
  - `branch_cnt` += 1;
  - on `mispredict`, also `mispred_cnt` += 1.
  - Both counters saturate at 0xFFFF.
- `stall`=1 freezes all state: FSM, table, counters, `redirect_pc`. Outputs hold their current values.

## Timing
- Reset values:
  - all table entries 01;
  - state RUN;
  - `redirect`=0, `flush`=0;
  - `redirect_pc`=0;
  - both counters 0;
  - `pred_taken`=0 for every PC.
- `pred_taken` has zero latency, combinational from `if_pc`.
- Same-cycle read and write of the same index: the read returns the pre-update value. There is no bypass.
- Misprediction latency: resolution in cycle t gives `redirect`+`flush` in t+1, `flush` only in t+2, RUN in t+3. A branch can be resolved again in t+3.
- Back-to-back correctly predicted branches: one update per cycle, no bubbles.
- `rst_n` asserted mid-recovery returns the block to RUN immediately, with outputs deasserted. The table reinitializes to 01.

## Structure
- Shared package (`cpu_pkg`):
  - FSM state typedef (RUN/REDIRECT/DRAIN);
  - counter encoding constants (`SNT`, `WNT`, `WT`, `ST`);
  - `INSTR_BRANCH` = 2'b10, shared with `brancher`.
- One sub-module is natural: `bht_2bit`, which holds the counter array with one combinational read port, one synchronous update port and async reset.
- FSM and performance counters stay in `branch_sequencer`.

## Test plan
- Reset, then sweep `if_pc` over 0x00–0x3C: `pred_taken`=0 for all; counters 0; `redirect`/`flush` 0.
- Branch at 0x40 resolved taken three times with correct `ex_pred_taken` each time:
  - predictor steps 01→10→11→11;
  - `pred_taken`=1 for `if_pc`=0x40 after the first update;
  - `branch_cnt`=3, `mispred_cnt`=0, no flush.
- Misprediction with `ex_pc`=0x100, `ex_pred_taken`=0, BranchTaken=1, `ex_target`=0x200:
  - t+1: `redirect`=1, `redirect_pc`=0x200, `flush`=1;
  - t+2: `flush`=1 only;
  - t+3: idle.
- Not-taken misprediction with `ex_pc`=0xFFFFFFFC: `redirect_pc`=0x00000000.
- A second mispredicting `ex_is_branch` during REDIRECT and DRAIN: ignored; table and counters unchanged.
- `stall`=1 held for 3 cycles during REDIRECT: `redirect` stays high for all 3 cycles; DRAIN follows the release.
- `rst_n` pulsed low in DRAIN: outputs 0 immediately, entry 0x100 back to 01.
